// File: rtl/mqam_modulator.sv
// Run-time selectable QPSK/16QAM/64QAM modulator: serial bits are packed into Gray-coded
// I/Q levels and mixed with an NCO cos/sin carrier into a single passband sample.
module mqam_modulator #(
    parameter int unsigned CARRIER_W  = 8,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned LUT_ADDR_W = 6,
    parameter int unsigned SPS        = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic [PHASE_W-1:0]   fcw,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [CARRIER_W+4:0] mod_out,
    output logic                 out_valid,
    output logic                 sym_strobe,
    output logic                 underrun
);

    localparam int unsigned CNT_W = $clog2(SPS);
    localparam int PEAK = 2 ** (CARRIER_W - 1) - 1;
    localparam int unsigned QW = LUT_ADDR_W - 2;
    localparam logic [LUT_ADDR_W-1:0] QUARTER = LUT_ADDR_W'(2 ** QW);

    // Quarter-wave sine in 16 steps, scaled from a 127-peak reference to the carrier peak.
    localparam int QROM [17] = '{
        0,             12 * PEAK / 127,  25 * PEAK / 127,  37 * PEAK / 127,
        49 * PEAK / 127,  60 * PEAK / 127,  71 * PEAK / 127,  81 * PEAK / 127,
        90 * PEAK / 127,  98 * PEAK / 127,  106 * PEAK / 127, 112 * PEAK / 127,
        117 * PEAK / 127, 122 * PEAK / 127, 125 * PEAK / 127, 126 * PEAK / 127,
        PEAK
    };

    // Folds an address within a half cycle onto the 0..16 quarter-wave index.
    function automatic logic [4:0] quarter_idx(input logic [LUT_ADDR_W-2:0] a);
        logic [31:0] off;
        off = 32'(a[QW-1:0]);
        if (a[QW]) off = (32'd1 << QW) - off;
        return 5'((off << 4) >> QW);
    endfunction

    logic [1:0]                  mode_q;
    logic [2:0]                  bit_cnt_q;
    logic [5:0]                  shreg_q;
    logic [CNT_W-1:0]            sym_cnt_q;
    logic signed [3:0]           lvl_i_q, lvl_q_q;
    logic                        lv_q;
    logic [PHASE_W-1:0]          phase_q;
    logic signed [CARRIER_W-1:0] sin_q, cos_q;
    logic signed [CARRIER_W+3:0] prod_i_q, prod_q_q;
    logic                        pv_q;
    logic signed [CARRIER_W+4:0] sum_q;
    logic                        ov_q;

    logic [2:0]                  k;
    logic                        boundary;
    logic                        accept;
    logic [2:0]                  i_g, q_g, i_b, q_b;
    logic [3:0]                  offset;
    logic signed [3:0]           lvl_i, lvl_q;
    logic [LUT_ADDR_W-1:0]       sin_addr, cos_addr;
    logic signed [CARRIER_W-1:0] sin_mag, cos_mag, sin_c, cos_c;

    always_comb begin
        case (mode_q)
            2'b00:   k = 3'd2;
            2'b10:   k = 3'd6;
            default: k = 3'd4;
        endcase
    end

    assign boundary   = (sym_cnt_q == CNT_W'(SPS - 1));
    assign bit_ready  = (bit_cnt_q < k) || boundary;
    assign accept     = bit_valid && bit_ready;
    assign sym_strobe = boundary;
    assign underrun   = boundary && (bit_cnt_q != k);

    always_comb begin
        i_g    = 3'b000;
        q_g    = 3'b000;
        offset = 4'd3;
        case (k)
            3'd2: begin
                i_g    = {2'b00, shreg_q[1]};
                q_g    = {2'b00, shreg_q[0]};
                offset = 4'd1;
            end
            3'd6: begin
                i_g    = {shreg_q[5], shreg_q[3], shreg_q[1]};
                q_g    = {shreg_q[4], shreg_q[2], shreg_q[0]};
                offset = 4'd7;
            end
            default: begin
                i_g = {1'b0, shreg_q[3], shreg_q[1]};
                q_g = {1'b0, shreg_q[2], shreg_q[0]};
            end
        endcase
        i_b   = {i_g[2], i_g[2] ^ i_g[1], ^i_g};
        q_b   = {q_g[2], q_g[2] ^ q_g[1], ^q_g};
        // 4-bit wraparound yields the signed level directly.
        lvl_i = {i_b, 1'b0} - offset;
        lvl_q = {q_b, 1'b0} - offset;
    end

    always_comb begin
        sin_addr = phase_q[PHASE_W-1 -: LUT_ADDR_W];
        cos_addr = sin_addr + QUARTER;
        sin_mag  = CARRIER_W'(QROM[quarter_idx(sin_addr[LUT_ADDR_W-2:0])]);
        cos_mag  = CARRIER_W'(QROM[quarter_idx(cos_addr[LUT_ADDR_W-2:0])]);
        sin_c    = sin_addr[LUT_ADDR_W-1] ? -sin_mag : sin_mag;
        cos_c    = cos_addr[LUT_ADDR_W-1] ? -cos_mag : cos_mag;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sym_cnt_q <= '0;
            lvl_i_q   <= '0;
            lvl_q_q   <= '0;
            lv_q      <= 1'b0;
            phase_q   <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            prod_i_q  <= '0;
            prod_q_q  <= '0;
            pv_q      <= 1'b0;
            sum_q     <= '0;
            ov_q      <= 1'b0;
        end else begin
            sym_cnt_q <= boundary ? '0 : sym_cnt_q + CNT_W'(1);
            if (bit_cnt_q == 3'd0) mode_q <= mode;

            if (boundary && (bit_cnt_q == k)) begin
                lvl_i_q   <= lvl_i;
                lvl_q_q   <= lvl_q;
                lv_q      <= 1'b1;
                bit_cnt_q <= accept ? 3'd1 : 3'd0;
                shreg_q   <= {5'b00000, accept & bit_in};
            end else begin
                if (boundary) begin
                    lvl_i_q <= '0;
                    lvl_q_q <= '0;
                    lv_q    <= 1'b0;
                end
                // Partial symbols survive an underrun and keep filling.
                if (accept) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    shreg_q   <= {shreg_q[4:0], bit_in};
                end
            end

            phase_q  <= phase_q + fcw;
            sin_q    <= sin_c;
            cos_q    <= cos_c;
            prod_i_q <= (CARRIER_W + 4)'(lvl_i_q) * (CARRIER_W + 4)'(cos_q);
            prod_q_q <= (CARRIER_W + 4)'(lvl_q_q) * (CARRIER_W + 4)'(sin_q);
            pv_q     <= lv_q;
            sum_q    <= (CARRIER_W + 5)'(prod_i_q) + (CARRIER_W + 5)'(prod_q_q);
            ov_q     <= pv_q;
        end
    end

    assign mod_out   = sum_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_mqam_modulator.sv
// Self-checking bench for mqam_modulator: directed and randomized bit streams compared
// each cycle against a behavioural symbol/carrier model.
module tb_mqam_modulator;

    localparam int PW  = 16;
    localparam int AW  = 6;
    localparam int SPS = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [15:0] fcw;
    logic        bit_in, bit_valid, bit_ready;
    logic [12:0] mod_out;
    logic        out_valid, sym_strobe, underrun;

    int n_cmp = 0;
    int n_bad = 0;

    int m_t, m_cnt, m_bits, m_k, m_phase, cur_i, cur_q, cur_v, last_t;
    int q_i[$], q_q[$], q_v[$], q_p[$];

    logic              exp_rdy, exp_stb, exp_und, exp_ov;
    logic              obs_rdy, obs_stb, obs_und, obs_ov;
    logic signed [31:0] exp_mod, obs_mod;

    mqam_modulator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .fcw        (fcw),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .mod_out    (mod_out),
        .out_valid  (out_valid),
        .sym_strobe (sym_strobe),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    function automatic int ref_sin(input int a);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 64.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int gray_level(input int g, input int m);
        int b = 0;
        for (int s = 0; s < m; s++) b = b ^ (g >> s);
        return 2 * b - ((1 << m) - 1);
    endfunction

    function automatic int bits_per_sym(input logic [1:0] md);
        return (md == 2'b00) ? 2 : (md == 2'b10) ? 6 : 4;
    endfunction

    task automatic do_reset(input logic [1:0] md, input logic [15:0] f);
        mode      = md;
        fcw       = f;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_t = 0; m_cnt = 0; m_bits = 0; m_phase = 0;
        m_k = bits_per_sym(md);
        cur_i = 0; cur_q = 0; cur_v = 0;
        q_i.delete(); q_q.delete(); q_v.delete(); q_p.delete();
        for (int i = 0; i < 3; i++) begin
            q_i.push_back(0); q_q.push_back(0); q_v.push_back(0); q_p.push_back(0);
        end
    endtask

    // One clock: drive inputs, sample at negedge, predict, advance the model.
    task automatic step(input logic v, input logic b);
        int p, a, ci, cq, sym, ig, qg;
        logic bnd, acc;
        bit_valid = v;
        bit_in    = b;
        @(negedge clk);
        ci = q_i.pop_front();
        cq = q_q.pop_front();
        p  = q_p.pop_front();
        exp_ov  = (q_v.pop_front() != 0);
        a       = p >> (PW - AW);
        exp_mod = ci * ref_sin((a + 16) % 64) + cq * ref_sin(a);
        bnd     = (m_t % SPS) == SPS - 1;
        exp_rdy = (m_cnt < m_k) || bnd;
        exp_stb = bnd;
        exp_und = bnd && (m_cnt < m_k);
        obs_rdy = bit_ready;
        obs_stb = sym_strobe;
        obs_und = underrun;
        obs_ov  = out_valid;
        obs_mod = $signed(mod_out);
        acc = v && exp_rdy;
        if (bnd && m_cnt == m_k) begin
            sym = m_bits & ((1 << m_k) - 1);
            ig = 0;
            qg = 0;
            for (int j = m_k - 1; j >= 1; j -= 2) begin
                ig = (ig << 1) | ((sym >> j) & 1);
                qg = (qg << 1) | ((sym >> (j - 1)) & 1);
            end
            cur_i  = gray_level(ig, m_k / 2);
            cur_q  = gray_level(qg, m_k / 2);
            cur_v  = 1;
            m_bits = acc ? int'(b) : 0;
            m_cnt  = acc ? 1 : 0;
        end else begin
            if (bnd) begin
                cur_i = 0; cur_q = 0; cur_v = 0;
            end
            if (acc) begin
                m_bits = ((m_bits << 1) | int'(b)) & 'h3F;
                m_cnt++;
            end
        end
        q_i.push_back(cur_i);
        q_q.push_back(cur_q);
        q_v.push_back(cur_v);
        q_p.push_back(m_phase);
        m_phase = (m_phase + int'(fcw)) & 'hFFFF;
        last_t = m_t;
        m_t++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(2'b00, 16'd0);
        step(1'b0, 1'b0);
        n_cmp++;
        if ({obs_rdy, obs_ov, obs_stb, obs_und, obs_mod} !== {4'b1000, 32'sd0}) begin
            n_bad++;
            $display("FAIL reset_state rdy,ov,stb,und=%b mod=%0d want 1000 mod=0",
                     {obs_rdy, obs_ov, obs_stb, obs_und}, obs_mod);
        end
    endtask

    task automatic test_qpsk();
        do_reset(2'b00, 16'd0);
        for (int t = 0; t < 40; t++) begin
            step(t < 2, 1'b1);
            n_cmp++;
            if ({obs_rdy, obs_stb, obs_und, obs_ov, obs_mod} !==
                {exp_rdy, exp_stb, exp_und, exp_ov, exp_mod}) begin
                n_bad++;
                $display("FAIL qpsk_model t=%0d got %b mod=%0d want %b mod=%0d", last_t,
                         {obs_rdy, obs_stb, obs_und, obs_ov}, obs_mod,
                         {exp_rdy, exp_stb, exp_und, exp_ov}, exp_mod);
            end
            if (t == 18) begin
                n_cmp++;
                if (obs_mod !== 32'sd127 || obs_ov !== 1'b1) begin
                    n_bad++;
                    $display("FAIL qpsk_11 mod=%0d ov=%b want 127 ov=1", obs_mod, obs_ov);
                end
            end
            if (t == 31) begin
                n_cmp++;
                if (obs_und !== 1'b1 || obs_stb !== 1'b1) begin
                    n_bad++;
                    $display("FAIL underrun_pulse und=%b stb=%b want 1 1", obs_und, obs_stb);
                end
            end
            if (t == 34) begin
                n_cmp++;
                if (obs_mod !== 32'sd0 || obs_ov !== 1'b0) begin
                    n_bad++;
                    $display("FAIL underrun_out mod=%0d ov=%b want 0 ov=0", obs_mod, obs_ov);
                end
            end
        end
    endtask

    task automatic test_16qam();
        do_reset(2'b01, 16'd0);
        for (int t = 0; t < 22; t++) begin
            step(t < 4, t == 0);
            n_cmp++;
            if ({obs_rdy, obs_stb, obs_und, obs_ov, obs_mod} !==
                {exp_rdy, exp_stb, exp_und, exp_ov, exp_mod}) begin
                n_bad++;
                $display("FAIL qam16_model t=%0d got %b mod=%0d want %b mod=%0d", last_t,
                         {obs_rdy, obs_stb, obs_und, obs_ov}, obs_mod,
                         {exp_rdy, exp_stb, exp_und, exp_ov}, exp_mod);
            end
            if (t == 17) begin
                n_cmp++;
                if (obs_ov !== 1'b0) begin
                    n_bad++;
                    $display("FAIL qam16_latency ov=%b at n+2 want 0", obs_ov);
                end
            end
            if (t == 18) begin
                n_cmp++;
                if (obs_mod !== 32'sd381 || obs_ov !== 1'b1) begin
                    n_bad++;
                    $display("FAIL qam16_1000 mod=%0d ov=%b want 381 ov=1", obs_mod, obs_ov);
                end
            end
        end
    endtask

    task automatic test_64qam();
        do_reset(2'b10, 16'd0);
        for (int t = 0; t < 36; t++) begin
            step((t < 6) || (t >= 15 && t < 21), t == 0);
            n_cmp++;
            if ({obs_rdy, obs_stb, obs_und, obs_ov, obs_mod} !==
                {exp_rdy, exp_stb, exp_und, exp_ov, exp_mod}) begin
                n_bad++;
                $display("FAIL qam64_model t=%0d got %b mod=%0d want %b mod=%0d", last_t,
                         {obs_rdy, obs_stb, obs_und, obs_ov}, obs_mod,
                         {exp_rdy, exp_stb, exp_und, exp_ov}, exp_mod);
            end
            if (t == 18) begin
                n_cmp++;
                if (obs_mod !== 32'sd889) begin
                    n_bad++;
                    $display("FAIL qam64_100000 mod=%0d want 889", obs_mod);
                end
            end
            if (t == 34) begin
                n_cmp++;
                if (obs_mod !== -32'sd889) begin
                    n_bad++;
                    $display("FAIL qam64_000000 mod=%0d want -889", obs_mod);
                end
            end
        end
    endtask

    task automatic test_continuous();
        do_reset(2'b01, 16'd0);
        for (int t = 0; t < 80; t++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            n_cmp++;
            if ({obs_rdy, obs_stb, obs_und, obs_ov, obs_mod} !==
                {exp_rdy, exp_stb, exp_und, exp_ov, exp_mod}) begin
                n_bad++;
                $display("FAIL continuous_model t=%0d got %b mod=%0d want %b mod=%0d", last_t,
                         {obs_rdy, obs_stb, obs_und, obs_ov}, obs_mod,
                         {exp_rdy, exp_stb, exp_und, exp_ov}, exp_mod);
            end
            if (t == 4 || t == 15) begin
                n_cmp++;
                if (obs_rdy !== (t == 15)) begin
                    n_bad++;
                    $display("FAIL ready_gate t=%0d rdy=%b want %b", t, obs_rdy, t == 15);
                end
            end
        end
    endtask

    task automatic test_quadrature();
        int want [4] = '{127, 127, -127, -127};
        do_reset(2'b00, 16'd16384);
        for (int t = 0; t < 26; t++) begin
            step((t < 2) || (t >= 16 && t < 18), t == 0);
            n_cmp++;
            if ({obs_rdy, obs_stb, obs_und, obs_ov, obs_mod} !==
                {exp_rdy, exp_stb, exp_und, exp_ov, exp_mod}) begin
                n_bad++;
                $display("FAIL quad_model t=%0d got %b mod=%0d want %b mod=%0d", last_t,
                         {obs_rdy, obs_stb, obs_und, obs_ov}, obs_mod,
                         {exp_rdy, exp_stb, exp_und, exp_ov}, exp_mod);
            end
            if (t >= 18 && t <= 21) begin
                n_cmp++;
                if (obs_mod !== 32'(want[t-18])) begin
                    n_bad++;
                    $display("FAIL quadrature t=%0d mod=%0d want %0d", t, obs_mod, want[t-18]);
                end
            end
        end
        do_reset(2'b00, 16'd16384);
        step(1'b1, 1'b1);
        n_cmp++;
        if ({obs_rdy, obs_ov, obs_stb, obs_und, obs_mod} !== {4'b1000, 32'sd0}) begin
            n_bad++;
            $display("FAIL reset_mid rdy,ov,stb,und=%b mod=%0d want 1000 mod=0",
                     {obs_rdy, obs_ov, obs_stb, obs_und}, obs_mod);
        end
    endtask

    task automatic test_random();
        int thresh;
        for (int r = 0; r < 6; r++) begin
            do_reset(2'($urandom_range(0, 3)), 16'($urandom));
            thresh = $urandom_range(3, 8);
            for (int t = 0; t < 150; t++) begin
                step(($urandom % 8) < thresh, 1'($urandom_range(0, 1)));
                n_cmp++;
                if ({obs_rdy, obs_stb, obs_und, obs_ov, obs_mod} !==
                    {exp_rdy, exp_stb, exp_und, exp_ov, exp_mod}) begin
                    n_bad++;
                    $display("FAIL random_model r=%0d t=%0d got %b mod=%0d want %b mod=%0d",
                             r, last_t, {obs_rdy, obs_stb, obs_und, obs_ov}, obs_mod,
                             {exp_rdy, exp_stb, exp_und, exp_ov}, exp_mod);
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        mode      = 2'b00;
        fcw       = 16'd0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        test_reset();
        test_qpsk();
        test_16qam();
        test_64qam();
        test_continuous();
        test_quadrature();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
